// File: rtl/nios2_oci_ram_arbiter.sv
// -----------------------------------------------------------------------------
// nios2_oci_ram_arbiter
//
// Shares the single-port OCI debug RAM (1-cycle read latency) between the JTAG
// debug path and the CPU's Avalon-MM debug-memory slave. JTAG commands come in
// as single-cycle strobes. They are held in a one-deep pending register and use
// an auto-incrementing address. CPU accesses are stalled with waitrequest
// until the FSM has served them.
//
// Ports
//   clk, reset           system clock; synchronous active-high reset
//   jtag_addr_load/addr  load the JTAG address register
//   jtag_rd / jtag_wr    JTAG command strobes (jtag_wdata sampled with jtag_wr)
//   jtag_rdata(_valid)   JTAG read result and its one-cycle update pulse
//   jtag_busy            JTAG command pending or in service
//   jtag_overrun(_clr)   sticky "JTAG strobe dropped" flag and its clear
//   avs_*                Avalon-MM slave (address, read, write, data, stall)
//   ram_*                RAM address, write enable, write data, read data
//
// Configuration
//   NIOS2_OCI_ARB_JTAG_PRIORITY_EN  defined: a pending JTAG command always wins
//                                   arbitration. Undefined: round-robin.
// -----------------------------------------------------------------------------
module nios2_oci_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_addr_load,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_rd,
    input  logic              jtag_wr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic [DATA_W-1:0] jtag_rdata,
    output logic              jtag_rdata_valid,
    output logic              jtag_busy,
    output logic              jtag_overrun,
    input  logic              jtag_overrun_clr,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_RDWAIT,
        JTAG_ACC,
        JTAG_RDWAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] jtag_addr_q;
    logic              pend_valid_q;
    logic              pend_write_q;
    logic [DATA_W-1:0] pend_data_q;
    logic              cpu_write_q;
    logic              grant_cpu, grant_jtag;

    logic jtag_in_service, jtag_active, jtag_drop, cpu_req;

    assign jtag_in_service = (state_q == JTAG_ACC) || (state_q == JTAG_RDWAIT);
    assign jtag_active     = pend_valid_q || jtag_in_service;
    // Any strobe arriving while a command is pending or in service is dropped.
    assign jtag_drop       = jtag_active && (jtag_rd || jtag_wr || jtag_addr_load);
    assign cpu_req         = avs_read || avs_write;

`ifndef NIOS2_OCI_ARB_JTAG_PRIORITY_EN
    typedef enum logic {GRANT_CPU, GRANT_JTAG} grant_t;
    grant_t last_grant_q;

    always_ff @(posedge clk) begin
        if (reset)           last_grant_q <= GRANT_JTAG;   // CPU wins the first tie
        else if (grant_cpu)  last_grant_q <= GRANT_CPU;
        else if (grant_jtag) last_grant_q <= GRANT_JTAG;
    end
`endif

    // Next-state and arbitration. Arbitration is evaluated in IDLE only.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        grant_cpu  = 1'b0;
        grant_jtag = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef NIOS2_OCI_ARB_JTAG_PRIORITY_EN
                if (pend_valid_q)  grant_jtag = 1'b1;
                else if (cpu_req)  grant_cpu  = 1'b1;
`else
                if (cpu_req && pend_valid_q) begin
                    if (last_grant_q == GRANT_JTAG) grant_cpu  = 1'b1;
                    else                            grant_jtag = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end else if (pend_valid_q) begin
                    grant_jtag = 1'b1;
                end
`endif
                if (grant_cpu)       state_d = CPU_ACC;
                else if (grant_jtag) state_d = JTAG_ACC;
            end
            CPU_ACC:     state_d = cpu_write_q  ? IDLE : CPU_RDWAIT;
            JTAG_ACC:    state_d = pend_write_q ? IDLE : JTAG_RDWAIT;
            CPU_RDWAIT:  state_d = IDLE;
            JTAG_RDWAIT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            jtag_addr_q      <= '0;
            pend_valid_q     <= 1'b0;
            pend_write_q     <= 1'b0;
            pend_data_q      <= '0;
            cpu_write_q      <= 1'b0;
            jtag_rdata       <= '0;
            jtag_rdata_valid <= 1'b0;
            jtag_overrun     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q          <= state_d;
            jtag_rdata_valid <= 1'b0;

            // The write/read decision is taken once at grant. Write wins if
            // both are asserted.
            if (grant_cpu) cpu_write_q <= avs_write;

            // Pending slot is freed when the command enters service. The
            // payload stays in pend_data_q for the duration of JTAG_ACC.
            if (grant_jtag) pend_valid_q <= 1'b0;

            if (!jtag_active) begin
                // Loading and commanding in the same cycle is allowed. The
                // access happens later, so it sees the new address.
                if (jtag_addr_load) jtag_addr_q <= jtag_addr;
                if (jtag_rd || jtag_wr) begin
                    pend_valid_q <= 1'b1;
                    pend_write_q <= jtag_wr;
                    pend_data_q  <= jtag_wdata;
                end
            end

            // Auto-increment; wraps naturally at 2^ADDR_W.
            if (state_q == JTAG_ACC) jtag_addr_q <= jtag_addr_q + ADDR_W'(1);

            if (state_q == JTAG_RDWAIT) begin
                jtag_rdata       <= ram_rdata;
                jtag_rdata_valid <= 1'b1;
            end

            // A new drop outranks a clear in the same cycle.
            if (jtag_drop)             jtag_overrun <= 1'b1;
            else if (jtag_overrun_clr) jtag_overrun <= 1'b0;
        end
    end

    // RAM mux and Avalon handshake. The write enable and the handshake are
    // gated with reset, so an access aborted by reset has no effect.
    always_comb begin
        ram_addr        = jtag_addr_q;
        ram_wdata       = pend_data_q;
        if ((state_q == CPU_ACC) || (state_q == CPU_RDWAIT)) begin
            ram_addr  = avs_address;
            ram_wdata = avs_writedata;
        end
        ram_we          = !reset && (((state_q == CPU_ACC)  && cpu_write_q) ||
                                     ((state_q == JTAG_ACC) && pend_write_q));
        avs_waitrequest = reset || !(((state_q == CPU_ACC) && cpu_write_q) ||
                                     (state_q == CPU_RDWAIT));
    end

    assign avs_readdata = ram_rdata;
    assign jtag_busy    = !reset && jtag_active;

endmodule

// File: doc/nios2_oci_ram_arbiter.md
# nios2_oci_ram_arbiter

Sysclk-domain arbiter and sequencer for the Nios II on-chip-instrumentation (OCI) debug RAM (256 x 32, single port, 1-cycle read latency). It shares the RAM between two requesters. The first is the JTAG debug path, which sends single-cycle command strobes with an auto-incrementing address register. The second is the CPU's Avalon-MM debug-memory slave port. The block sits beside the debug-slave sysclk logic and converts its take-action strobes and 38-bit jdo payload into sequenced RAM accesses.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width; the JTAG address wraps at 2^ADDR_W-1
- DATA_W, 32, RAM/Avalon data width

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- jtag_addr_load  in  1  one-cycle strobe; load the JTAG address register from jtag_addr
- jtag_addr  in  ADDR_W  address value for jtag_addr_load
- jtag_rd  in  1  one-cycle strobe; read RAM at the JTAG address
- jtag_wr  in  1  one-cycle strobe; write jtag_wdata at the JTAG address
- jtag_wdata  in  DATA_W  write data, sampled with jtag_wr
- jtag_rdata  out  DATA_W  read result, held until the next JTAG read completes
- jtag_rdata_valid  out  1  one-cycle pulse when jtag_rdata updates
- jtag_busy  out  1  high while a JTAG command is pending or in service
- jtag_overrun  out  1  sticky; a JTAG strobe was dropped
- jtag_overrun_clr  in  1  clears jtag_overrun
- avs_address  in  ADDR_W  CPU word address
- avs_read / avs_write  in  1  CPU access request, held until accepted
- avs_writedata  in  DATA_W  CPU write data
- avs_readdata  out  DATA_W  CPU read data, valid when avs_read=1 and avs_waitrequest=0
- avs_waitrequest  out  1  Avalon stall
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr

## Operation
- FSM states: IDLE, CPU_ACC, CPU_RDWAIT, JTAG_ACC, JTAG_RDWAIT.
- JTAG strobes are latched into a one-deep pending register (op, data).
- A jtag_rd or jtag_wr strobe that arrives while a command is pending or in service is dropped and sets jtag_overrun. jtag_addr_load in that situation is also dropped and sets jtag_overrun.
- If jtag_addr_load and jtag_rd/jtag_wr arrive in the same cycle, the access uses the newly loaded address.
- The JTAG address increments at the end of JTAG_ACC and wraps from 2^ADDR_W-1 to 0.
- Arbitration happens in IDLE only. With a single requester, that requester is granted. When both request, round-robin applies: the requester not granted last wins. After reset, last_grant = JTAG, so the CPU wins the first tie.
- Transitions:
  - IDLE -> CPU_ACC or JTAG_ACC on grant.
  - CPU_ACC -> IDLE for a write, -> CPU_RDWAIT for a read.
  - JTAG_ACC -> IDLE for a write, -> JTAG_RDWAIT for a read.
  - Both RDWAIT states -> IDLE.
- ram_we = (state is a write ACC) AND NOT reset.
- ram_addr and ram_wdata are muxed from the granted source.

## Timing
- Reset values:
  - FSM = IDLE
  - avs_waitrequest = 1
  - ram_we = 0
  - jtag_rdata = 0, jtag_rdata_valid = 0
  - jtag_busy = 0, jtag_overrun = 0
  - JTAG address = 0, pending cleared
- CPU request seen at cycle 0 in IDLE:
  - Write: RAM written in cycle 1; waitrequest low in cycle 1. Total 2 cycles.
  - Read: waitrequest low in cycle 2, avs_readdata = ram_rdata. Total 3 cycles.
- JTAG strobe at cycle 0:
  - Pending at cycle 1, JTAG_ACC at cycle 2.
  - Write: committed in cycle 2.
  - Read: JTAG_RDWAIT at cycle 3; jtag_rdata_valid pulses in cycle 4.
- jtag_busy goes high in cycle 1 and drops in the cycle the FSM returns to IDLE.
- Reset asserted mid-operation aborts the operation: no RAM write in the reset cycle, pending command discarded, no rdata_valid pulse.
- jtag_overrun_clr together with a new overrun in the same cycle: the flag stays set.

## Configuration
- NIOS2_OCI_ARB_JTAG_PRIORITY_EN defined: a pending JTAG command always wins the IDLE arbitration over the CPU, and last_grant is unused.
- Undefined: round-robin as described above.

## Test plan
- Load address 0x10, then jtag_wr 0xDEADBEEF followed by jtag_wr 0x12345678 -> RAM[0x10] = 0xDEADBEEF and RAM[0x11] = 0x12345678; then load 0x10 and jtag_rd -> jtag_rdata = 0xDEADBEEF with the valid pulse 4 cycles after the strobe.
- CPU write 0xCAFEF00D to 0x20, then CPU read 0x20 -> waitrequest low after 2 and 3 cycles; readdata = 0xCAFEF00D.
- CPU read and JTAG read requested in the same cycle right after reset -> CPU served first and JTAG second. A second simultaneous pair -> CPU again, since last_grant = JTAG; with the macro defined -> JTAG served first both times.
- Load 0xFF, then two jtag_wr strobes -> the second write lands at 0x00.
- jtag_wr followed by jtag_rd one cycle later -> jtag_rd dropped, jtag_overrun = 1; jtag_overrun_clr -> 0.
- Reset asserted during JTAG_ACC of a write to 0x30 -> RAM[0x30] unchanged; all outputs return to their reset values.
